serial_adder: RTL and testbench

Bit-serial ripple-carry adder, the additive counterpart of the team's combinational borrow-chain subtractor. It computes `S = a + b + cin` one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop, and reports completion with a start/done handshake. It sits beside the subtractor in the arithmetic datapath wherever area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_WIDTH_DEF = 4;

    function automatic int sa_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the one arithmetic cell shared by every bit position of serial_adder.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple-carry adder: S = a + b + cin, LSB first, one bit per clock.
// Optional signed-overflow output V is enabled with SERIAL_ADDER_OVF_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one sum bit per cycle through the full-adder cell
//   DONE  | done pulse; start here re-enters RUN directly
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             C
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int            CW   = sa_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] ps_q, ps_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             v_q, v_d;
`endif

    logic             fa_s, fa_co;
    logic [WIDTH-1:0] ps_full;

    full_adder_cell u_fa (
        .x  (a_sh_q[0]),
        .y  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Only WIDTH-1 partial bits are stored; the final bit joins them straight into S.
    assign ps_full = {fa_s, ps_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        s_d     = s_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        v_d     = v_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    ps_d    = '0;
                    cnt_d   = '0;
                    carry_d = cin;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                ps_d    = ps_full[WIDTH-1:1];
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = ps_full;
                    c_d     = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB during the last bit.
                    v_d     = carry_q ^ fa_co;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            ps_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign C    = c_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4); V is checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, C;
    logic [W-1:0] S;
`ifdef SERIAL_ADDER_OVF_EN
    logic         V;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .C     (C)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vt[11];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Applies one start pulse and returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                          output int cyc, output int bcnt);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; cin = ic;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 4 * W) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cyc, bcnt, ndone, bad;

        //        a      b      cin   s      c     v
        vt[0]  = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};
        vt[1]  = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vt[2]  = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        vt[3]  = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vt[4]  = '{4'h3, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0};
        vt[5]  = '{4'h9, 4'hA, 1'b0, 4'h3, 1'b1, 1'b1};
        vt[6]  = '{4'h5, 4'h5, 1'b1, 4'hB, 1'b0, 1'b1};
        vt[7]  = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vt[8]  = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vt[9]  = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
        vt[10] = '{4'h6, 4'h9, 1'b1, 4'h0, 1'b1, 1'b0};

        #12;
        chk("reset_S",    32'(S),    32'd0);
        chk("reset_C",    32'(C),    32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("reset_V",    32'(V),    32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].cin, cyc, bcnt);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(W + 1));
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(W));
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_S", i), 32'(S), 32'(vt[i].s));
            chk($sformatf("v%0d_C", i), 32'(C), 32'(vt[i].c));
`ifdef SERIAL_ADDER_OVF_EN
            chk($sformatf("v%0d_V", i), 32'(V), 32'(vt[i].v));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // start during RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 4'h1; b = 4'h2; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'h3; b = 4'h3;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 4 * W) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_done_seen", 32'(done), 32'd1);
        chk("ign_S", 32'(S), 32'h3);
        chk("ign_C", 32'(C), 32'd0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("ign_extra_done", 32'(ndone), 32'd0);

        // back-to-back: start held in DONE
        run_op(4'h4, 4'h4, 1'b0, cyc, bcnt);
        chk("b2b_first_S", 32'(S), 32'h8);
        start = 1'b1; a = 4'h2; b = 4'h5; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", 32'(busy), 32'd1);
        cyc = 1;
        bad = 0;
        while (!done && cyc < 4 * W) begin
            if (S !== 4'h8) bad++;
            @(negedge clk);
            cyc++;
        end
        chk("b2b_S_stable", 32'(bad), 32'd0);
        chk("b2b_latency", 32'(cyc), 32'(W + 1));
        chk("b2b_S", 32'(S), 32'h7);

        // reset in the middle of RUN
        start = 1'b1; a = 4'hA; b = 4'h5; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_S",    32'(S),    32'd0);
        chk("mid_rst_C",    32'(C),    32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("mid_rst_V",    32'(V),    32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        bad   = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) bad++;
        end
        chk("post_rst_no_done", 32'(ndone), 32'd0);
        chk("post_rst_idle",    32'(bad),   32'd0);
        run_op(4'h1, 4'h1, 1'b0, cyc, bcnt);
        chk("post_rst_latency", 32'(cyc), 32'(W + 1));
        chk("post_rst_S", 32'(S), 32'h2);
        chk("post_rst_C", 32'(C), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
